// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the Ctrl decoder it drives:
// sequencer states, decoder mode encodings and the NOP word.
package Definitions;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_e;

  localparam logic [1:0] MODE_REG    = 2'b00;
  localparam logic [1:0] MODE_TARGET = 2'b01;
  localparam logic [1:0] MODE_IMM    = 2'b10;
  localparam logic [1:0] MODE_NOP    = 2'b11;

  localparam logic [8:0] NOP_WORD = 9'h000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM and Ctrl-decoder bus seen by the fetch sequencer; master is the
// sequencer side, slave is the ROM/Ctrl side.
interface fetch_sequencer_if #(
  parameter int PC_W = 9,
  parameter int IW   = 9
);
  logic [PC_W-1:0] InstrAddr;
  logic [IW-1:0]   InstrData;
  logic [IW-1:0]   Instruction;
  logic [IW-1:0]   PrevInstruction;
  logic [1:0]      CurrState;
  logic [2:0]      CMPBits;
  logic [1:0]      NextState;
  logic [IW-1:0]   PrevInstructionIn;
  logic [2:0]      CMPBitsIn;
  logic            CMPLoadEn;
  logic            BranchEn;
  logic [PC_W-1:0] BranchTarget;
  logic            Ack;

  modport master (
    output InstrAddr, Instruction, PrevInstruction, CurrState, CMPBits,
    input  InstrData, NextState, PrevInstructionIn, CMPBitsIn, CMPLoadEn,
           BranchEn, BranchTarget, Ack
  );

  modport slave (
    input  InstrAddr, Instruction, PrevInstruction, CurrState, CMPBits,
    output InstrData, NextState, PrevInstructionIn, CMPBitsIn, CMPLoadEn,
           BranchEn, BranchTarget, Ack
  );
endinterface

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter register: start load beats hold beats branch beats increment.
module program_counter #(
  parameter int              PC_W       = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            load_start,
  input  logic            load_branch,
  input  logic            incr,
  input  logic            hold,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            at_max
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_start)       pc_d = START_ADDR;
    else if (hold)        pc_d = pc_q;
    else if (load_branch) pc_d = branch_target;
    else if (incr)        pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pc_q <= START_ADDR;
    else        pc_q <= pc_d;
  end

  assign pc     = pc_q;
  assign at_max = (pc_q == '1);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing unit: owns PC, decoder mode, previous-instruction and
// compare-flag registers, and runs program start, execution and halt.
//
//   state    | meaning
//   SEQ_IDLE | after reset, waiting for Start
//   SEQ_RUN  | one instruction presented to Ctrl per cycle
//   SEQ_HALT | stopped by Ack (Done) or PC overrun (Fault); Start restarts
module fetch_sequencer
  import Definitions::*;
#(
  parameter int              PC_W       = 9,
  parameter int              IW         = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  fetch_sequencer_if.master   bus,
  output logic                Busy,
  output logic                Done,
  output logic                Fault,
  output logic [15:0]         CycleCount
);

  seq_state_e      state_q, state_d;
  logic [1:0]      curr_state_q, curr_state_d;
  logic [IW-1:0]   prev_instr_q, prev_instr_d;
  logic [2:0]      cmp_bits_q, cmp_bits_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic [15:0]     cycle_cnt_q, cycle_cnt_d;

  logic            run;
  logic            start_go;
  logic            overrun;
  logic            at_max;
  logic [PC_W-1:0] pc;

  assign run      = (state_q == SEQ_RUN);
  assign start_go = Start && !run;
  // The last address only overruns when nothing redirects or stops the program.
  assign overrun  = run && at_max && !bus.BranchEn && !bus.Ack;

  program_counter #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .Clk           (Clk),
    .Reset         (Reset),
    .load_start    (start_go),
    .load_branch   (run && bus.BranchEn),
    .incr          (run),
    .hold          (!run || bus.Ack || overrun),
    .branch_target (bus.BranchTarget),
    .pc            (pc),
    .at_max        (at_max)
  );

  always_comb begin
    state_d      = state_q;
    curr_state_d = curr_state_q;
    prev_instr_d = prev_instr_q;
    cmp_bits_d   = cmp_bits_q;
    done_d       = done_q;
    fault_d      = fault_q;
    cycle_cnt_d  = cycle_cnt_q;
    case (state_q)
      SEQ_RUN: begin
        cycle_cnt_d = sat_inc16(cycle_cnt_q);
        if (bus.Ack) begin
          curr_state_d = MODE_REG;
          done_d       = 1'b1;
          state_d      = SEQ_HALT;
        end else begin
          curr_state_d = bus.NextState;
          prev_instr_d = bus.PrevInstructionIn;
          if (bus.CMPLoadEn) cmp_bits_d = bus.CMPBitsIn;
          if (overrun) begin
            fault_d = 1'b1;
            state_d = SEQ_HALT;
          end
        end
      end
      default: begin
        if (Start) begin
          curr_state_d = MODE_REG;
          prev_instr_d = '0;
          cmp_bits_d   = '0;
          cycle_cnt_d  = '0;
          done_d       = 1'b0;
          fault_d      = 1'b0;
          state_d      = SEQ_RUN;
        end
      end
    endcase
    busy_d = (state_d == SEQ_RUN);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= SEQ_IDLE;
      curr_state_q <= MODE_REG;
      prev_instr_q <= '0;
      cmp_bits_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      curr_state_q <= curr_state_d;
      prev_instr_q <= prev_instr_d;
      cmp_bits_q   <= cmp_bits_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign bus.InstrAddr       = pc;
  assign bus.Instruction     = run ? bus.InstrData : IW'(NOP_WORD);
  assign bus.PrevInstruction = prev_instr_q;
  assign bus.CurrState       = curr_state_q;
  assign bus.CMPBits         = cmp_bits_q;
  assign Busy                = busy_q;
  assign Done                = done_q;
  assign Fault               = fault_q;
  assign CycleCount          = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a vector table plus hand sequences, each step's
// expected outputs queued when driven and compared after the clock edge.
module tb_fetch_sequencer;
  import Definitions::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Busy, Done, Fault;
  logic [15:0] CycleCount;

  always #5 Clk = ~Clk;

  fetch_sequencer_if #(.PC_W(9), .IW(9)) bif ();

  fetch_sequencer #(.PC_W(9), .IW(9), .START_ADDR(9'd0)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .bus        (bif),
    .Busy       (Busy),
    .Done       (Done),
    .Fault      (Fault),
    .CycleCount (CycleCount)
  );

  function automatic logic [8:0] rom_word(input logic [8:0] a);
    return a ^ 9'h15A;
  endfunction

  always_comb bif.InstrData = rom_word(bif.InstrAddr);

  typedef struct {
    logic        start, ack, ben;
    logic [8:0]  btgt;
    logic [1:0]  ns;
    logic [8:0]  pin;
    logic [2:0]  cin;
    logic        cld;
    logic [8:0]  addr;
    logic        busy, done, fault;
    logic [1:0]  cs;
    logic [8:0]  prev;
    logic [2:0]  cmp;
    logic [15:0] cnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(
    input logic s, a, b, input logic [8:0] bt, input logic [1:0] ns,
    input logic [8:0] pin, input logic [2:0] cin, input logic cld,
    input logic [8:0] addr, input logic busy, done, fault,
    input logic [1:0] cs, input logic [8:0] prev, input logic [2:0] cmp,
    input logic [15:0] cnt);
    vec_t v;
    v.start = s;  v.ack = a;  v.ben = b;  v.btgt = bt;  v.ns = ns;
    v.pin = pin;  v.cin = cin;  v.cld = cld;  v.addr = addr;
    v.busy = busy;  v.done = done;  v.fault = fault;  v.cs = cs;
    v.prev = prev;  v.cmp = cmp;  v.cnt = cnt;
    return v;
  endfunction

  // Plain RUN/HALT cycle with quiet Ctrl inputs and zeroed mode registers.
  function automatic vec_t quiet(input logic [8:0] addr, input logic busy,
                                 done, fault, input logic [15:0] cnt);
    return mk(0, 0, 0, 9'd0, 2'd0, 9'd0, 3'd0, 0, addr, busy, done, fault,
              2'd0, 9'd0, 3'd0, cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Start                 = v.start;
    bif.Ack               = v.ack;
    bif.BranchEn          = v.ben;
    bif.BranchTarget      = v.btgt;
    bif.NextState         = v.ns;
    bif.PrevInstructionIn = v.pin;
    bif.CMPBitsIn         = v.cin;
    bif.CMPLoadEn         = v.cld;
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    step_no++;
    drive(v);
    sb.push_back(v);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("addr",  32'(bif.InstrAddr), 32'(e.addr));
    check("busy",  32'(Busy), 32'(e.busy));
    check("done",  32'(Done), 32'(e.done));
    check("fault", 32'(Fault), 32'(e.fault));
    check("cs",    32'(bif.CurrState), 32'(e.cs));
    check("prev",  32'(bif.PrevInstruction), 32'(e.prev));
    check("cmp",   32'(bif.CMPBits), 32'(e.cmp));
    check("cnt",   32'(CycleCount), 32'(e.cnt));
    check("instr", 32'(bif.Instruction), e.busy ? 32'(rom_word(e.addr)) : 32'(NOP_WORD));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " addr"},  32'(bif.InstrAddr), 32'd0);
    check({tag, " busy"},  32'(Busy), 32'd0);
    check({tag, " done"},  32'(Done), 32'd0);
    check({tag, " fault"}, 32'(Fault), 32'd0);
    check({tag, " cs"},    32'(bif.CurrState), 32'd0);
    check({tag, " prev"},  32'(bif.PrevInstruction), 32'd0);
    check({tag, " cmp"},   32'(bif.CMPBits), 32'd0);
    check({tag, " cnt"},   32'(CycleCount), 32'd0);
    check({tag, " instr"}, 32'(bif.Instruction), 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    drive(quiet(9'd0, 0, 0, 0, 16'd0));
    repeat (2) @(posedge Clk);
    #1;
    check_reset_values("por");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // start, straight line, CMP load/hold, branch, mode changes, Ack+Start+branch
    tbl.push_back(mk(1,0,0,9'd0,  2'd0,9'h000,3'b000,0, 9'd0,  1,0,0, 2'd0,9'h000,3'b000,16'd0));
    tbl.push_back(mk(0,0,0,9'd0,  2'd0,9'h011,3'b000,0, 9'd1,  1,0,0, 2'd0,9'h011,3'b000,16'd1));
    tbl.push_back(mk(0,0,0,9'd0,  2'd0,9'h022,3'b010,1, 9'd2,  1,0,0, 2'd0,9'h022,3'b010,16'd2));
    tbl.push_back(mk(0,0,0,9'd0,  2'd0,9'h033,3'b111,0, 9'd3,  1,0,0, 2'd0,9'h033,3'b010,16'd3));
    tbl.push_back(mk(0,0,1,9'd200,2'd0,9'h044,3'b000,0, 9'd200,1,0,0, 2'd0,9'h044,3'b010,16'd4));
    tbl.push_back(mk(0,0,0,9'd0,  2'd1,9'h055,3'b000,0, 9'd201,1,0,0, 2'd1,9'h055,3'b010,16'd5));
    tbl.push_back(mk(0,0,0,9'd0,  2'd2,9'h066,3'b101,1, 9'd202,1,0,0, 2'd2,9'h066,3'b101,16'd6));
    tbl.push_back(mk(1,1,1,9'd5,  2'd3,9'h077,3'b111,1, 9'd202,0,1,0, 2'd0,9'h066,3'b101,16'd7));
    tbl.push_back(mk(0,0,0,9'd0,  2'd3,9'h1FF,3'b111,1, 9'd202,0,1,0, 2'd0,9'h066,3'b101,16'd7));
    tbl.push_back(mk(1,0,0,9'd0,  2'd0,9'h000,3'b000,0, 9'd0,  1,0,0, 2'd0,9'h000,3'b000,16'd0));
    tbl.push_back(mk(0,0,0,9'd0,  2'd1,9'h0AA,3'b000,0, 9'd1,  1,0,0, 2'd1,9'h0AA,3'b000,16'd1));
    tbl.push_back(mk(1,0,0,9'd0,  2'd0,9'h0BB,3'b000,0, 9'd2,  1,0,0, 2'd0,9'h0BB,3'b000,16'd2));
    tbl.push_back(mk(0,1,0,9'd0,  2'd1,9'h0CC,3'b000,0, 9'd2,  0,1,0, 2'd0,9'h0BB,3'b000,16'd3));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // five straight-line words, Ack on word 4, then held in HALT
    step(mk(1,0,0,9'd0,2'd0,9'd0,3'd0,0, 9'd0,1,0,0, 2'd0,9'd0,3'd0,16'd0));
    for (int i = 0; i < 4; i++) step(quiet(9'(i + 1), 1, 0, 0, 16'(i + 1)));
    step(mk(0,1,0,9'd0,2'd0,9'd0,3'd0,0, 9'd4,0,1,0, 2'd0,9'd0,3'd0,16'd5));
    step(quiet(9'd4, 0, 1, 0, 16'd5));

    // overrun at the last address, restart, then a legal branch from 511
    step(mk(1,0,0,9'd0,2'd0,9'd0,3'd0,0, 9'd0,1,0,0, 2'd0,9'd0,3'd0,16'd0));
    step(mk(0,0,1,9'd509,2'd0,9'd0,3'd0,0, 9'd509,1,0,0, 2'd0,9'd0,3'd0,16'd1));
    step(quiet(9'd510, 1, 0, 0, 16'd2));
    step(quiet(9'd511, 1, 0, 0, 16'd3));
    step(quiet(9'd511, 0, 0, 1, 16'd4));
    step(quiet(9'd511, 0, 0, 1, 16'd4));
    step(mk(1,0,0,9'd0,2'd0,9'd0,3'd0,0, 9'd0,1,0,0, 2'd0,9'd0,3'd0,16'd0));
    step(mk(0,0,1,9'd511,2'd0,9'd0,3'd0,0, 9'd511,1,0,0, 2'd0,9'd0,3'd0,16'd1));
    step(mk(0,0,1,9'd7,2'd0,9'd0,3'd0,0, 9'd7,1,0,0, 2'd0,9'd0,3'd0,16'd2));
    step(mk(0,1,0,9'd0,2'd0,9'd0,3'd0,0, 9'd7,0,1,0, 2'd0,9'd0,3'd0,16'd3));

    // asynchronous reset in the middle of RUN at PC=37
    step(mk(1,0,0,9'd0,2'd0,9'd0,3'd0,0, 9'd0,1,0,0, 2'd0,9'd0,3'd0,16'd0));
    step(mk(0,0,1,9'd36,2'd0,9'd0,3'd0,0, 9'd36,1,0,0, 2'd0,9'd0,3'd0,16'd1));
    step(mk(0,0,0,9'd0,2'd1,9'h123,3'b110,1, 9'd37,1,0,0, 2'd1,9'h123,3'b110,16'd2));
    drive(quiet(9'd0, 0, 0, 0, 16'd0));
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values("midrun");
    @(negedge Clk);
    Reset = 1'b1;
    step(quiet(9'd0, 0, 0, 0, 16'd0));
    step(mk(1,0,0,9'd0,2'd0,9'd0,3'd0,0, 9'd0,1,0,0, 2'd0,9'd0,3'd0,16'd0));
    step(quiet(9'd1, 1, 0, 0, 16'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
